// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: port ids, read-return tags and arbiter states.
// Port ids are sized for up to MAX_PORTS requesters so one package serves every build.
package sram_arb_pkg;

    localparam int MAX_READ_LAT = 4;
    localparam int MAX_PORTS    = 16;
    localparam int PORT_ID_W    = $clog2(MAX_PORTS);

    typedef logic [PORT_ID_W-1:0] port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port_id;
    } rd_tag_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    function automatic port_id_t next_port(input port_id_t p, input int n);
        if (int'(p) + 1 >= n) begin
            return '0;
        end else begin
            return p + port_id_t'(1);
        end
    endfunction

endpackage

// File: rtl/sram_arb_tag_pipe.sv
// Read-return tag pipeline: READ_LAT+1 stages of {valid, port_id}; the last stage
// lines up with SRAM read data and is decoded to a one-hot rvalid.
module sram_arb_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int READ_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  rd_tag_t            tag_i,
    output logic [N_PORTS-1:0] rvalid_o,
    output logic               busy_o
);

    localparam int STAGES = READ_LAT + 1;

    rd_tag_t stage_q [STAGES];

    // Shift the tag of every granted read toward the data-return slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Decode the last stage to a one-hot valid and flag any read still in flight.
    always_comb begin
        rvalid_o = '0;
        busy_o   = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            rvalid_o[p] = stage_q[STAGES-1].valid
                          & (stage_q[STAGES-1].port_id == port_id_t'(p));
        end
        for (int k = 0; k < STAGES; k++) begin
            busy_o = busy_o | stage_q[k].valid;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port buffer SRAM among N_PORTS requesters with bounded bursts.
// Optional `EXT_PRIORITY_EN: port 0 (external loader) gets strict, burst-unbounded priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int N_PORTS   = 4,
    parameter  int DATA_W    = 64,
    parameter  int DEPTH     = 256,
    parameter  int READ_LAT  = 1,
    parameter  int MAX_BURST = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_PORTS-1:0]      req_cenb_i,
    input  logic [N_PORTS-1:0]      req_wenb_i,
    input  logic [N_PORTS*AW-1:0]   req_addr_i,
    input  logic [N_PORTS*DATA_W-1:0] req_d_i,
    output logic [N_PORTS-1:0]      gnt_o,
    output logic [N_PORTS-1:0]      rvalid_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    mem_cenb_o,
    output logic                    mem_wenb_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]       mem_d_o,
    input  logic [DATA_W-1:0]       mem_q_i,
    output logic                    busy_o
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    port_id_t         owner_q, owner_d;
    port_id_t         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic                 mem_cenb_q, mem_wenb_q;
    logic [AW-1:0]        mem_addr_q;
    logic [DATA_W-1:0]    mem_d_q;

    logic [N_PORTS-1:0]   req;
    logic [2*N_PORTS-1:0] req_dbl;
    logic [N_PORTS-1:0]   gnt;
    logic                 owner_req, burst_ok, hold, pri, any_req, any_gnt;
    port_id_t             start, rr_win, win;
    int                   rr_off, rr_sum;

    logic                 sel_wenb;
    logic [AW-1:0]        sel_addr;
    logic [DATA_W-1:0]    sel_d;
    rd_tag_t              tag_in;
    logic                 tag_busy;

    // Arbitration: keep the current owner while its burst lasts, otherwise rotate.
    always_comb begin
        req       = ~req_cenb_i;
        owner_req = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            owner_req = owner_req | (req[p] & (owner_q == port_id_t'(p)));
        end
        burst_ok = (burst_cnt_q < BURST_MAX);
`ifdef EXT_PRIORITY_EN
        burst_ok = burst_ok | (owner_q == '0);
        start    = ((state_q == ARB_OWNED) && (owner_q != '0)) ? next_port(owner_q, N_PORTS)
                                                                : rr_ptr_q;
        pri      = req[0] & ~((state_q == ARB_OWNED) && (owner_q == '0));
`else
        start    = (state_q == ARB_OWNED) ? next_port(owner_q, N_PORTS) : rr_ptr_q;
        pri      = 1'b0;
`endif
        hold    = (state_q == ARB_OWNED) & owner_req & burst_ok;
        any_req = |req;

        // Rotate requests so bit 0 is the start port; the lowest set bit is the winner.
        req_dbl = {req, req} >> start;
        rr_off  = 0;
        for (int off = N_PORTS - 1; off >= 0; off--) begin
            rr_off = req_dbl[off] ? off : rr_off;
        end
        rr_sum = int'(start) + rr_off;
        rr_win = port_id_t'((rr_sum >= N_PORTS) ? (rr_sum - N_PORTS) : rr_sum);

        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        win         = '0;
        any_gnt     = 1'b0;
        if (pri) begin
            // A pre-empted owner resumes first once port 0 lets go.
            win         = '0;
            any_gnt     = 1'b1;
            owner_d     = '0;
            burst_cnt_d = CNT_W'(1);
            state_d     = ARB_OWNED;
            rr_ptr_d    = hold ? owner_q : start;
        end else if (hold) begin
            win         = owner_q;
            any_gnt     = 1'b1;
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
        end else if (any_req) begin
            win         = rr_win;
            any_gnt     = 1'b1;
            owner_d     = rr_win;
            burst_cnt_d = CNT_W'(1);
            state_d     = ARB_OWNED;
            rr_ptr_d    = start;
        end else begin
            state_d     = ARB_IDLE;
            rr_ptr_d    = start;
            burst_cnt_d = '0;
        end
    end

    // One-hot grant and AND-OR mux of the winning port's command.
    always_comb begin
        gnt      = '0;
        sel_wenb = 1'b0;
        sel_addr = '0;
        sel_d    = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            gnt[p]   = any_gnt & ~rst_i & (win == port_id_t'(p));
            sel_wenb = sel_wenb | (gnt[p] & req_wenb_i[p]);
            sel_addr = sel_addr | ({AW{gnt[p]}} & req_addr_i[p*AW +: AW]);
            sel_d    = sel_d | ({DATA_W{gnt[p]}} & req_d_i[p*DATA_W +: DATA_W]);
        end
        tag_in.valid   = (|gnt) & sel_wenb;
        tag_in.port_id = win;
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Registered SRAM command; address and data hold their last value while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_cenb_q <= 1'b1;
            mem_wenb_q <= 1'b1;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
        end else if (|gnt) begin
            mem_cenb_q <= 1'b0;
            mem_wenb_q <= sel_wenb;
            mem_addr_q <= sel_addr;
            mem_d_q    <= sel_d;
        end else begin
            mem_cenb_q <= 1'b1;
            mem_wenb_q <= 1'b1;
        end
    end

    sram_arb_tag_pipe #(
        .N_PORTS  (N_PORTS),
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .tag_i    (tag_in),
        .rvalid_o (rvalid_o),
        .busy_o   (tag_busy)
    );

    assign gnt_o      = gnt;
    assign mem_cenb_o = mem_cenb_q;
    assign mem_wenb_o = mem_wenb_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_d_o    = mem_d_q;
    assign rdata_o    = (|rvalid_o) ? mem_q_i : '0;
    assign busy_o     = (|gnt) | ~mem_cenb_q | tag_busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a one-cycle-latency SRAM model.
// Build with +define+EXT_PRIORITY_EN to select the priority expectations.
module tb_sram_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NP-1:0]     req_cenb_i, req_wenb_i;
    logic [NP*AW-1:0]  req_addr_i;
    logic [NP*DW-1:0]  req_d_i;
    logic [NP-1:0]     gnt_o, rvalid_o;
    logic [DW-1:0]     rdata_o, mem_d_o, mem_q_i;
    logic              mem_cenb_o, mem_wenb_o, busy_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     sram [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_cenb_i (req_cenb_i),
        .req_wenb_i (req_wenb_i),
        .req_addr_i (req_addr_i),
        .req_d_i    (req_d_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .mem_cenb_o (mem_cenb_o),
        .mem_wenb_o (mem_wenb_o),
        .mem_addr_o (mem_addr_o),
        .mem_d_o    (mem_d_o),
        .mem_q_i    (mem_q_i),
        .busy_o     (busy_o)
    );

    // Single-port SRAM model: read data appears one cycle after the command cycle.
    always @(posedge clk) begin
        if (!mem_cenb_o) begin
            if (!mem_wenb_o) sram[mem_addr_o] <= mem_d_o;
            else             mem_q_i <= sram[mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_cenb_i = '1;
        req_wenb_i = '1;
        req_addr_i = '0;
        req_d_i    = '0;
    endtask

    task automatic set_req(input int p, input bit en, input bit wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] d);
        req_cenb_i[p]          = ~en;
        req_wenb_i[p]          = ~wr;
        req_addr_i[p*AW +: AW] = addr;
        req_d_i[p*DW +: DW]    = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_req();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [3:0] oh(input int p);
        return 4'b0001 << p;
    endfunction

    function automatic logic [3:0] exp_pri(input int c);
`ifdef EXT_PRIORITY_EN
        return (c == 3 || c == 4) ? 4'b0001 : 4'b0100;
`else
        return (c == 8 || c == 9) ? 4'b0001 : 4'b0100;
`endif
    endfunction

    initial begin
        int cnt [NP];
        int p0_cnt;
        bit p3_done;
        logic [3:0] bb_exp [5];

        // Reset held with every port requesting.
        rst_i      = 1'b1;
        req_cenb_i = '0;
        req_wenb_i = '1;
        req_addr_i = '0;
        req_d_i    = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("rst_gnt", 64'(gnt_o), 64'h0);
            chk("rst_cenb", 64'(mem_cenb_o), 64'h1);
            chk("rst_rvalid", 64'(rvalid_o), 64'h0);
            tick();
        end
        rst_i = 1'b0;
        clear_req();
        #2;
        chk("post_rst_busy", 64'(busy_o), 64'h0);
        chk("post_rst_rdata", rdata_o, 64'h0);
        chk("post_rst_addr", 64'(mem_addr_o), 64'h0);

        // Port 2 writes then reads back address 0x10.
        tick();
        set_req(2, 1'b1, 1'b1, 8'h10, BEEF);
        #2;
        chk("wr_gnt", 64'(gnt_o), 64'h4);
        tick();
        clear_req();
        #2;
        chk("wr_cenb", 64'(mem_cenb_o), 64'h0);
        chk("wr_wenb", 64'(mem_wenb_o), 64'h0);
        chk("wr_addr", 64'(mem_addr_o), 64'h10);
        chk("wr_data", mem_d_o, BEEF);
        tick();
        set_req(2, 1'b1, 1'b0, 8'h10, 64'h0);
        #2;
        chk("rd_gnt", 64'(gnt_o), 64'h4);
        chk("rd_no_rvalid_t", 64'(rvalid_o), 64'h0);
        tick();
        clear_req();
        #2;
        chk("rd_cenb", 64'(mem_cenb_o), 64'h0);
        chk("rd_wenb", 64'(mem_wenb_o), 64'h1);
        chk("rd_no_rvalid_t1", 64'(rvalid_o), 64'h0);
        chk("rd_busy", 64'(busy_o), 64'h1);
        tick();
        #2;
        chk("rd_rvalid", 64'(rvalid_o), 64'h4);
        chk("rd_rdata", rdata_o, BEEF);
        tick();
        #2;
        chk("rd_done_busy", 64'(busy_o), 64'h0);
        chk("rd_done_rvalid", 64'(rvalid_o), 64'h0);

        // Fairness: all four ports read continuously; bursts of 8 in port order.
        do_reset();
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int c = 0; c < 34; c++) begin
            for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, 8'h10, 64'h0);
            #2;
            chk($sformatf("fair_gnt_c%0d", c), 64'(gnt_o), 64'(oh((c / 8) % 4)));
            if (c >= 2) begin
                chk($sformatf("fair_rvalid_c%0d", c), 64'(rvalid_o), 64'(oh(((c - 2) / 8) % 4)));
                chk($sformatf("fair_rdata_c%0d", c), rdata_o, BEEF);
            end
            for (int p = 0; p < NP; p++) begin
                if (c < 32 && gnt_o[p]) cnt[p]++;
            end
            tick();
        end
        for (int p = 0; p < NP; p++) chk($sformatf("fair_cnt_p%0d", p), 64'(cnt[p]), 64'd8);
        clear_req();
        tick();
        tick();
        tick();

        // Burst break: port 1 drops after 3 grants; waiting port 3 follows with no bubble.
        do_reset();
        bb_exp[0] = 4'b0010; bb_exp[1] = 4'b0010; bb_exp[2] = 4'b0010;
        bb_exp[3] = 4'b1000; bb_exp[4] = 4'b0000;
        p3_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clear_req();
            set_req(1, c < 3, 1'b0, 8'h10, 64'h0);
            set_req(3, !p3_done, 1'b0, 8'hFF, 64'h0);
            #2;
            chk($sformatf("bb_gnt_c%0d", c), 64'(gnt_o), 64'(bb_exp[c]));
            if (gnt_o[3]) p3_done = 1'b1;
            tick();
        end
        clear_req();
        tick();
        tick();
        tick();

        // Reset arrives the cycle after a read grant; its return must vanish.
        do_reset();
        set_req(1, 1'b1, 1'b0, 8'h10, 64'h0);
        #2;
        chk("mr_gnt", 64'(gnt_o), 64'h2);
        tick();
        rst_i = 1'b1;
        #2;
        chk("mr_gnt_in_rst", 64'(gnt_o), 64'h0);
        tick();
        rst_i = 1'b0;
        clear_req();
        #2;
        chk("mr_rvalid", 64'(rvalid_o), 64'h0);
        chk("mr_busy", 64'(busy_o), 64'h0);
        tick();
        #2;
        chk("mr_rvalid_late", 64'(rvalid_o), 64'h0);

        // Port 0 asks for two grants while port 2 is three grants into its burst.
        do_reset();
        p0_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            clear_req();
            set_req(2, 1'b1, 1'b0, 8'h10, 64'h0);
            set_req(0, (c >= 3) && (p0_cnt < 2), 1'b0, 8'h00, 64'h0);
            #2;
            chk($sformatf("pri_gnt_c%0d", c), 64'(gnt_o), 64'(exp_pri(c)));
            if (gnt_o[0]) p0_cnt++;
            tick();
        end
        clear_req();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
